regfile_wb_ctrl: RTL

Write-side controller for the 32x32 register file. It merges two producers onto the file's single write port: the in-order primary path (ALU/load, single-cycle) and the multi-cycle MUL/DIV unit (valid/ready). The MUL/DIV results are buffered in a small FIFO. A per-register busy scoreboard stalls issue while any operand or destination still has a MUL/DIV result outstanding.

---
 rtl/cpu_regs_pkg.sv | 14 +
 rtl/wb_fifo.sv | 55 +++++
 rtl/regfile_wb_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/cpu_regs_pkg.sv
// Shared register-file definitions: address/data widths and the writeback request record.
package cpu_regs_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// First-word-fall-through FIFO holding MUL/DIV results until the write port is free.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < CNT_FULL) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port arbiter: primary path has priority, MUL/DIV results drain from a FIFO,
// and a busy scoreboard stalls decode on outstanding MUL/DIV destinations.
module regfile_wb_ctrl
  import cpu_regs_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pri_valid,
  input  logic [ADDR_W-1:0]   pri_addr,
  input  logic [DATA_W-1:0]   pri_data,
  input  logic                sec_valid,
  output logic                sec_ready,
  input  logic [ADDR_W-1:0]   sec_addr,
  input  logic [DATA_W-1:0]   sec_data,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_addr,
  input  logic [ADDR_W-1:0]   chk_addr1,
  input  logic [ADDR_W-1:0]   chk_addr2,
  input  logic [ADDR_W-1:0]   chk_dst,
  output logic                stall,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [CW-1:0]            fifo_count;
  logic [ADDR_W+DATA_W-1:0] fifo_din;
  logic [ADDR_W+DATA_W-1:0] fifo_dout;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic [ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]        head_data;
  wb_req_t                  sel;
  logic                     sel_valid;
  logic [NUM_REGS-1:0]      busy_next;

  // sec_ready is taken from the registered count only, so it never looks ahead to a pop.
  assign sec_ready = (fifo_count < CNT_FULL);
  assign fifo_push = sec_valid && sec_ready;
  assign fifo_din  = {sec_addr, sec_data};
  assign head_addr = fifo_dout[ADDR_W+DATA_W-1 -: ADDR_W];
  assign head_data = fifo_dout[DATA_W-1:0];

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel       = '0;
    fifo_pop  = 1'b0;
    if (pri_valid) begin
      sel_valid = 1'b1;
      sel.addr  = pri_addr;
      sel.data  = pri_data;
    end else if (fifo_count != '0) begin
      sel_valid = 1'b1;
      fifo_pop  = 1'b1;
      sel.addr  = head_addr;
      sel.data  = head_data;
    end
  end

  // Clear on pop first, then set on issue, so a same-edge issue to that register wins.
  always_comb begin
    busy_next = busy_vec;
    if (fifo_pop && (head_addr != REG_ZERO)) begin
      busy_next[head_addr] = 1'b0;
    end
    if (iss_valid && (iss_addr != REG_ZERO)) begin
      busy_next[iss_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  assign stall = busy_vec[chk_addr1] | busy_vec[chk_addr2] | busy_vec[chk_dst];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy_vec <= '0;
    end else begin
      rf_we <= sel_valid && (sel.addr != REG_ZERO);
      if (sel_valid) begin
        rf_waddr <= sel.addr;
        rf_wdata <= sel.data;
      end
      busy_vec <= busy_next;
    end
  end

endmodule
